// File: rtl/bru_pkg.sv
// Shared types and helpers for the EX-stage branch resolve unit.
package bru_pkg;

    typedef enum logic {
        BRU_IDLE  = 1'b0,
        BRU_FLUSH = 1'b1
    } bru_state_e;

    localparam int FLUSH_CNT_W = 3;
    localparam int BRU_MAX_XLEN = 64;

    // Computed at the widest supported XLEN; callers truncate, which keeps pc+4 modulo 2^XLEN.
    function automatic logic [BRU_MAX_XLEN-1:0] next_pc(
        input logic [BRU_MAX_XLEN-1:0] pc,
        input logic [BRU_MAX_XLEN-1:0] target,
        input logic                    taken
    );
        return taken ? target : pc + BRU_MAX_XLEN'(4);
    endfunction

endpackage

// File: rtl/bru_perf_cnt.sv
// Saturating counter pair: accepted conditional branches and their mispredicts.
module bru_perf_cnt (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        inc_branch,
    input  logic        inc_mispred,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    logic [1:0]  inc;
    logic [31:0] count [2];

    assign inc = {inc_mispred, inc_branch};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [31:0] count_reg;
            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    count_reg <= '0;
                end else if (inc[gi] && (count_reg != 32'hFFFF_FFFF)) begin
                    count_reg <= count_reg + 32'd1;
                end
            end
            assign count[gi] = count_reg;
        end
    endgenerate

    assign branch_cnt  = count[0];
    assign mispred_cnt = count[1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: redirect/flush on mispredict, predictor update one cycle later.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    input  logic            i_is_branch,
    input  logic            i_is_jump,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pred_taken,
    input  logic            i_cmp_taken,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_stall,
    output logic            o_flush,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_bp_wen,
    output logic [XLEN-1:0] o_bp_pc,
    output logic            o_bp_taken,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]     o_branch_cnt,
    output logic [31:0]     o_mispred_cnt,
`endif
    output logic            o_busy
);

    bru_state_e             state_reg, state_next;
    logic [FLUSH_CNT_W-1:0] cnt_reg, cnt_next;

    logic            accept;
    logic            is_cond;
    logic            actual_taken;
    logic            mispredict;
    logic [XLEN-1:0] correct_pc;

    logic            redirect_valid_reg;
    logic [XLEN-1:0] redirect_pc_reg;
    logic            bp_wen_reg;
    logic [XLEN-1:0] bp_pc_reg;
    logic            bp_taken_reg;

    // Only control-transfer instructions arriving while idle and unstalled are resolved.
    assign accept       = i_valid & ~i_stall & (state_reg == BRU_IDLE) & (i_is_branch | i_is_jump);
    assign is_cond      = i_is_branch & ~i_is_jump;
    assign actual_taken = i_is_jump | (i_is_branch & i_cmp_taken);
    assign mispredict   = accept & (i_pred_taken != actual_taken);
    assign correct_pc   = XLEN'(next_pc(BRU_MAX_XLEN'(i_pc), BRU_MAX_XLEN'(i_target), actual_taken));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_reg <= BRU_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            BRU_IDLE: begin
                if (mispredict) begin
                    state_next = BRU_FLUSH;
                    cnt_next   = FLUSH_CNT_W'(FLUSH_CYCLES);
                end
            end
            BRU_FLUSH: begin
                // Flush length is fixed by the front-end depth, so stalls do not extend it.
                cnt_next = cnt_reg - FLUSH_CNT_W'(1);
                if (cnt_reg <= FLUSH_CNT_W'(1)) begin
                    state_next = BRU_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = BRU_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_flush = (state_reg == BRU_FLUSH);
        o_busy  = (state_reg != BRU_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
            bp_wen_reg         <= 1'b0;
            bp_pc_reg          <= '0;
            bp_taken_reg       <= 1'b0;
        end else begin
            redirect_valid_reg <= mispredict;
            bp_wen_reg         <= accept & is_cond;
            if (mispredict) begin
                redirect_pc_reg <= correct_pc;
            end
            if (accept && is_cond) begin
                bp_pc_reg    <= i_pc;
                bp_taken_reg <= actual_taken;
            end
        end
    end

    assign o_redirect_valid = redirect_valid_reg;
    assign o_redirect_pc    = redirect_pc_reg;
    assign o_bp_wen         = bp_wen_reg;
    assign o_bp_pc          = bp_pc_reg;
    assign o_bp_taken       = bp_taken_reg;

`ifdef BRU_PERF_CNT_EN
    bru_perf_cnt u_perf_cnt (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .inc_branch  (accept & is_cond),
        .inc_mispred (mispredict & is_cond),
        .branch_cnt  (o_branch_cnt),
        .mispred_cnt (o_mispred_cnt)
    );
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a scoreboard of expected redirect/update events.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic            valid;
    logic            is_branch;
    logic            is_jump;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic            cmp_taken;
    logic [XLEN-1:0] target;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            bp_wen;
    logic [XLEN-1:0] bp_pc;
    logic            bp_taken;
    logic            busy;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]     branch_cnt;
    logic [31:0]     mispred_cnt;
`endif

    typedef struct packed {
        logic            redir;
        logic [XLEN-1:0] rpc;
        logic            wen;
        logic [XLEN-1:0] bpc;
        logic            btaken;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .XLEN(XLEN)) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_valid          (valid),
        .i_is_branch      (is_branch),
        .i_is_jump        (is_jump),
        .i_pc             (pc),
        .i_pred_taken     (pred_taken),
        .i_cmp_taken      (cmp_taken),
        .i_target         (target),
        .i_stall          (stall),
        .o_flush          (flush),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_bp_wen         (bp_wen),
        .o_bp_pc          (bp_pc),
        .o_bp_taken       (bp_taken),
`ifdef BRU_PERF_CNT_EN
        .o_branch_cnt     (branch_cnt),
        .o_mispred_cnt    (mispred_cnt),
`endif
        .o_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock; the scoreboard front (or an all-quiet entry) is what must appear now.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.redir});
        if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
        chk("bp_wen", {31'd0, bp_wen}, {31'd0, e.wen});
        if (e.wen) begin
            chk("bp_pc", bp_pc, e.bpc);
            chk("bp_taken", {31'd0, bp_taken}, {31'd0, e.btaken});
        end
        $display("[TB] t=%0t flush=%0b busy=%0b redir=%0b rpc=%0h wen=%0b bpc=%0h taken=%0b",
                 $time, flush, busy, redirect_valid, redirect_pc, bp_wen, bp_pc, bp_taken);
    endtask

    task automatic push_expect(input logic [31:0] p, input logic br, input logic jmp,
                               input logic pred, input logic cmp, input logic [31:0] tgt);
        exp_t e;
        logic act;
        act      = jmp | (br & cmp);
        e.redir  = (pred != act);
        e.rpc    = act ? tgt : p + 32'd4;
        e.wen    = br & ~jmp;
        e.bpc    = p;
        e.btaken = act;
        sb.push_back(e);
    endtask

    // Present one instruction for a single cycle; live=1 when the bench expects it accepted.
    task automatic issue(input logic [31:0] p, input logic br, input logic jmp,
                         input logic pred, input logic cmp, input logic [31:0] tgt,
                         input logic live);
        valid      = 1'b1;
        is_branch  = br;
        is_jump    = jmp;
        pc         = p;
        pred_taken = pred;
        cmp_taken  = cmp;
        target     = tgt;
        if (live) push_expect(p, br, jmp, pred, cmp, tgt);
        step();
        valid = 1'b0;
    endtask

    task automatic check_flush(input string tag, input logic f);
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, f});
    endtask

    initial begin
        reset_n    = 1'b0;
        valid      = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        pc         = '0;
        pred_taken = 1'b0;
        cmp_taken  = 1'b0;
        target     = '0;
        stall      = 1'b0;

        step();
        step();
        check_flush("reset", 1'b0);
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        chk("reset_bp_pc", bp_pc, 32'h0);
        chk("reset_bp_taken", {31'd0, bp_taken}, 32'h0);
        reset_n = 1'b1;

        // Case 1: not-taken prediction, taken branch.
        issue(32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 32'h180, 1'b1);
        check_flush("c1_f1", 1'b1);
        step();
        check_flush("c1_f2", 1'b1);
        step();
        check_flush("c1_end", 1'b0);

        // Case 2: taken prediction, not-taken branch falls through to pc+4.
        issue(32'h200, 1'b1, 1'b0, 1'b1, 1'b0, 32'h280, 1'b1);
        check_flush("c2_f1", 1'b1);
        step();
        check_flush("c2_f2", 1'b1);
        step();
        check_flush("c2_end", 1'b0);

        // Case 3: correct prediction, only the predictor update.
        issue(32'h300, 1'b1, 1'b0, 1'b1, 1'b1, 32'h380, 1'b1);
        check_flush("c3", 1'b0);
        step();
        check_flush("c3_after", 1'b0);
`ifdef BRU_PERF_CNT_EN
        chk("branch_cnt_3", branch_cnt, 32'd3);
        chk("mispred_cnt_2", mispred_cnt, 32'd2);
`endif

        // Case 4: JAL redirects but never updates; update fields hold their last value.
        issue(32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 1'b1);
        check_flush("c4_f1", 1'b1);
        chk("c4_bp_pc_hold", bp_pc, 32'h300);
        chk("c4_bp_taken_hold", {31'd0, bp_taken}, 32'd1);
        step();
        step();
        check_flush("c4_end", 1'b0);

        // Case 5: a would-be mispredict arriving during FLUSH is squashed.
        issue(32'h800, 1'b1, 1'b0, 1'b0, 1'b1, 32'h880, 1'b1);
        check_flush("c5_f1", 1'b1);
        issue(32'h804, 1'b1, 1'b0, 1'b0, 1'b1, 32'h900, 1'b0);
        check_flush("c5_f2", 1'b1);
        step();
        check_flush("c5_end", 1'b0);

        // Case 6: stalled mispredict resolves once, after the stall drops; stall does not stretch the flush.
        valid      = 1'b1;
        is_branch  = 1'b1;
        is_jump    = 1'b0;
        pc         = 32'h600;
        pred_taken = 1'b0;
        cmp_taken  = 1'b1;
        target     = 32'h680;
        stall      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_flush("c6_stall", 1'b0);
        end
        stall = 1'b0;
        push_expect(32'h600, 1'b1, 1'b0, 1'b0, 1'b1, 32'h680);
        step();
        valid = 1'b0;
        stall = 1'b1;
        check_flush("c6_f1", 1'b1);
        step();
        check_flush("c6_f2", 1'b1);
        step();
        check_flush("c6_end", 1'b0);
        stall = 1'b0;

        // Case 7: pc+4 wraps to zero at the top of the address space.
        issue(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 1'b1);
        step();
        step();
        check_flush("c7_end", 1'b0);

        // Case 8: reset in the middle of a flush.
        issue(32'h700, 1'b1, 1'b0, 1'b0, 1'b1, 32'h780, 1'b1);
        check_flush("c8_f1", 1'b1);
        reset_n = 1'b0;
        step();
        check_flush("c8_reset", 1'b0);
        chk("c8_redirect_pc", redirect_pc, 32'h0);
        chk("c8_bp_pc", bp_pc, 32'h0);
        reset_n = 1'b1;

        // Case 9: normal operation after reset; non-control instructions are ignored.
        issue(32'hA00, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB00, 1'b0);
        check_flush("c9_nonctl", 1'b0);
        issue(32'hA04, 1'b1, 1'b0, 1'b0, 1'b0, 32'hB00, 1'b1);
        check_flush("c9", 1'b0);

`ifdef BRU_PERF_CNT_EN
        // Saturation: preload both counters to all-ones, then add a mispredicting branch.
        #1;
        force dut.u_perf_cnt.gen_cnt[0].count_reg = 32'hFFFF_FFFF;
        force dut.u_perf_cnt.gen_cnt[1].count_reg = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_perf_cnt.gen_cnt[0].count_reg;
        release dut.u_perf_cnt.gen_cnt[1].count_reg;
        issue(32'hC00, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC80, 1'b1);
        chk("branch_cnt_sat", branch_cnt, 32'hFFFF_FFFF);
        chk("mispred_cnt_sat", mispred_cnt, 32'hFFFF_FFFF);
        step();
        step();
`endif

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
